pipelined_logic_unit: RTL and testbench

Parametrised, registered successor to the team's fixed 8-bit bitwise gate arrays. Performs one of eight bitwise operations on two WIDTH-bit operands behind a valid/ready handshake with one output register stage. Adds a multi-beat XOR-accumulate (checksum fold) mode and status flags (zero, parity). Sits in the ALU logic lane beside the adder datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/logic_op_core.sv | 27 ++
 rtl/pipelined_logic_unit.sv | 117 +++++++++++
 tb/tb_pipelined_logic_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic lane: op encodings and accumulate FSM states.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_ACC  = 3'd7;

  typedef enum logic {
    StIdle,
    StAcc
  } acc_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational WIDTH-bit bitwise op mux; op 7 yields a ^ b (fold is added upstream).
module logic_op_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_ACC:  y = a ^ b;
    endcase
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake, XOR-accumulate fold and
// zero/parity status flags.
module pipelined_logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_first,
  input  logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             acc_busy
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q;
  logic             zero_q, parity_q;
  logic [WIDTH-1:0] acc_q;
  acc_state_e       state_q;

  logic             accept;
  logic             is_acc;
  logic             load_out;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] result;

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op(op),
    .a (a),
    .b (b),
    .y (core_y)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_acc   = ACC_EN && (op == OP_ACC);
  assign fold     = (acc_first ? '0 : acc_q) ^ a ^ b;
  // Non-final fold beats update only the accumulator and produce no output beat.
  assign load_out = accept && (!is_acc || acc_last);
  assign result   = is_acc ? fold : core_y;

  always_comb begin
    out_valid_d = out_valid_q;
    if (load_out) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_out) begin
        y_q      <= result;
        zero_q   <= ~|result;
        parity_q <= ^result;
      end
    end
  end

  if (ACC_EN) begin : g_acc
    acc_state_e       state_d;
    logic [WIDTH-1:0] acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        acc_q   <= '0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
      end
    end

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      if (accept && is_acc) begin
        state_d = acc_last ? StIdle : StAcc;
        acc_d   = acc_last ? '0 : fold;
      end
    end
  end else begin : g_no_acc
    assign state_q = StIdle;
    assign acc_q   = '0;
  end

  always_comb begin
    acc_busy = (state_q == StAcc);
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed self-checking bench for pipelined_logic_unit (WIDTH=8, ACC_EN=1).
module tb_pipelined_logic_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_first;
  logic       acc_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
  logic       acc_busy;

  int tests;
  int fails;

  pipelined_logic_unit #(
    .WIDTH (8),
    .ACC_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .acc_first(acc_first),
    .acc_last (acc_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero     (zero),
    .parity   (parity),
    .acc_busy (acc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat, let one rising edge pass, return 1 time unit after it.
  task automatic beat(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                      input logic first, input logic last);
    op        = o;
    a         = va;
    b         = vb;
    acc_first = first;
    acc_last  = last;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Status vector: {out_valid, y, zero, parity, acc_busy}
  task automatic test_reset();
    logic [11:0] exp_v;
    exp_v = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tests++;
    if ({out_valid, y, zero, parity, acc_busy} !== exp_v || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: got ov,y,z,p,busy=%h rdy=%b want %h rdy=1",
               {out_valid, y, zero, parity, acc_busy}, in_ready, exp_v);
    end
  endtask

  task automatic test_ops();
    logic [7:0] exp_y [7];
    exp_y = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h0F};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = 3'(i); a = 8'hF0; b = 8'h3C; in_valid = 1'b1; acc_first = 0; acc_last = 0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ops_in_ready op=%0d: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || y !== exp_y[i]) begin
        fails++;
        $display("FAIL op%0d: got ov=%b y=%h want ov=1 y=%h", i, out_valid, y, exp_y[i]);
      end
    end
    idle_cycle();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ops_drain: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_flags();
    beat(3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0);
    tests++;
    if ({y, zero, parity} !== {8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL flags_zero: got y=%h z=%b p=%b want y=00 z=1 p=0", y, zero, parity);
    end
    beat(3'd1, 8'h01, 8'h00, 1'b0, 1'b0);
    tests++;
    if ({y, zero, parity} !== {8'h01, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL flags_one: got y=%h z=%b p=%b want y=01 z=0 p=1", y, zero, parity);
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(3'd0, 8'hFF, 8'h55, 1'b0, 1'b0);
    // Next beat (OR 0F|F0 = FF) waits while output is stalled.
    op = 3'd1; a = 8'h0F; b = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h55) begin
        fails++;
        $display("FAIL stall_hold c%0d: got rdy=%b ov=%b y=%h want rdy=0 ov=1 y=55",
                 i, in_ready, out_valid, y);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release_rdy: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b1 || y !== 8'hFF) begin
      fails++;
      $display("FAIL stall_replace: got ov=%b y=%h want ov=1 y=FF", out_valid, y);
    end
    idle_cycle();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_drain: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_fold();
    out_ready = 1'b1;
    beat(3'd7, 8'h11, 8'h22, 1'b1, 1'b0);
    tests++;
    if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fold_b1: got busy=%b ov=%b want busy=1 ov=0", acc_busy, out_valid);
    end
    beat(3'd7, 8'h44, 8'h00, 1'b0, 1'b0);
    tests++;
    if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fold_b2: got busy=%b ov=%b want busy=1 ov=0", acc_busy, out_valid);
    end
    beat(3'd7, 8'h08, 8'h80, 1'b0, 1'b1);
    tests++;
    if ({out_valid, y, zero, parity, acc_busy} !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL fold_last: got ov=%b y=%h z=%b p=%b busy=%b want 1 FF 0 0 0",
               out_valid, y, zero, parity, acc_busy);
    end
    idle_cycle();
    tests++;
    if (out_valid !== 1'b0 || acc_busy !== 1'b0) begin
      fails++;
      $display("FAIL fold_after: got ov=%b busy=%b want 0 0", out_valid, acc_busy);
    end
  endtask

  task automatic test_interleave();
    beat(3'd7, 8'h0F, 8'h00, 1'b1, 1'b0);
    beat(3'd0, 8'hFF, 8'h0F, 1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'h0F || acc_busy !== 1'b1) begin
      fails++;
      $display("FAIL interleave_and: got ov=%b y=%h busy=%b want 1 0F 1",
               out_valid, y, acc_busy);
    end
    // Fold continues from the intact partial 0F: 0F ^ 30 = 3F.
    beat(3'd7, 8'h30, 8'h00, 1'b0, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'h3F || acc_busy !== 1'b0) begin
      fails++;
      $display("FAIL interleave_resume: got ov=%b y=%h busy=%b want 1 3F 0",
               out_valid, y, acc_busy);
    end
    beat(3'd7, 8'h0F, 8'h00, 1'b1, 1'b0);
    beat(3'd7, 8'h01, 8'h00, 1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'h01 || acc_busy !== 1'b0) begin
      fails++;
      $display("FAIL restart: got ov=%b y=%h busy=%b want 1 01 0", out_valid, y, acc_busy);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    beat(3'd7, 8'h12, 8'h34, 1'b1, 1'b0);
    beat(3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || y !== 8'hFF || acc_busy !== 1'b1) begin
      fails++;
      $display("FAIL prereset: got ov=%b y=%h busy=%b want 1 FF 1", out_valid, y, acc_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, y, zero, parity, acc_busy} !== {1'b1 ^ 1'b1, 8'h00, 1'b1, 1'b0, 1'b0}
        || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got ov=%b y=%h z=%b p=%b busy=%b rdy=%b want 0 00 1 0 0 1",
               out_valid, y, zero, parity, acc_busy, in_ready);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    beat(3'd7, 8'hAA, 8'h00, 1'b0, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || y !== 8'hAA || acc_busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_fold: got ov=%b y=%h busy=%b want 1 AA 0",
               out_valid, y, acc_busy);
    end
    idle_cycle();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 8'h00;
    b         = 8'h00;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    out_ready = 1'b1;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_ops();
    test_flags();
    test_backpressure();
    test_fold();
    test_interleave();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
